// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state type for the UART TX arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_FRAME_BITS = 11;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_arb_fifo.sv
// Synchronous FIFO shared by all requesters; push ignored when full, pop ignored when empty.
module uart_arb_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full comes from the registered count, so a pop never frees a slot in the same cycle.
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter + FIFO + pacing FSM sharing one UART transmitter.
// Optional macro UART_ARB_CRLF_EN: LF bytes are expanded to CR,LF on the wire.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_CLKS = 4800
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [8*N_REQ-1:0]            req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [7:0]                    uart_wr_data,
  output logic                          uart_wr_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(FRAME_CLKS);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CLKS - 2);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_wr_data;
  logic [PTR_W-1:0] r_rr_ptr;

  logic [PTR_W-1:0] w_cand;
  logic [PTR_W-1:0] w_grant_idx;
  logic             w_found;
  logic             w_grant_any;
  logic [7:0]       w_push_data;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_head;
  logic             w_pop;
  logic             w_load;
  logic [7:0]       w_load_data;

`ifdef UART_ARB_CRLF_EN
  logic             r_pending_lf;
  logic             w_pending_nxt;
`endif

  // Wrapping search starting at the RR pointer; the first valid requester wins.
  always_comb begin
    w_cand      = r_rr_ptr;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
      w_cand = (w_cand == LAST_REQ) ? '0 : w_cand + 1'b1;
    end
  end

  assign w_grant_any = w_found && !w_fifo_full && !rst;

  always_comb begin
    req_ready   = '0;
    w_push_data = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (w_grant_idx == PTR_W'(j)) begin
        req_ready[j] = w_grant_any;
        w_push_data  = req_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + 1'b1;
    end
  end

  uart_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_grant_any),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_data = w_fifo_head;
`ifdef UART_ARB_CRLF_EN
    w_pending_nxt = r_pending_lf;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef UART_ARB_CRLF_EN
        if (r_pending_lf) begin
          w_load        = 1'b1;
          w_load_data   = ASCII_LF;
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_SEND;
        end else if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
          if (w_fifo_head == ASCII_LF) begin
            w_load_data   = ASCII_CR;
            w_pending_nxt = 1'b1;
          end
        end
`else
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
`endif
      end
      ST_SEND: begin
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // SEND(1) + WAIT(FRAME_CLKS-2) + IDLE(1) gives exactly FRAME_CLKS between strobes.
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_wr_data <= w_load_data;
      end
    end
  end

`ifdef UART_ARB_CRLF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending_lf <= 1'b0;
    end else begin
      r_pending_lf <= w_pending_nxt;
    end
  end

  assign busy = !w_fifo_empty || (r_state != ST_IDLE) || r_pending_lf;
`else
  assign busy = !w_fifo_empty || (r_state != ST_IDLE);
`endif

  assign uart_wr_en   = (r_state == ST_SEND);
  assign uart_wr_data = r_wr_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration plus hand sequences.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ      = 2;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FRAME_CLKS = 20;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  uart_wr_data;
  logic        uart_wr_en;
  logic        busy;
  logic [3:0]  fifo_count;

  uart_tx_arbiter #(
    .N_REQ      (N_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_CLKS (FRAME_CLKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_wr_data (uart_wr_data),
    .uart_wr_en   (uart_wr_en),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_ready;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
`ifdef UART_ARB_CRLF_EN
    if (b == 8'h0A) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(b);
    end
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic wait_idle(input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    at_sample();
    while (busy && n < max_cyc) begin
      at_sample();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ia;
    int ib;
    int sent;
    int pulses_before;
    logic [1:0] er;
    logic [7:0] b;

    tbl[0] = '{valid: 2'b00, d0: 8'hEE, d1: 8'hEE, exp_ready: 2'b00};
    tbl[1] = '{valid: 2'b01, d0: 8'h11, d1: 8'hEE, exp_ready: 2'b01};
    tbl[2] = '{valid: 2'b11, d0: 8'h33, d1: 8'h22, exp_ready: 2'b10};
    tbl[3] = '{valid: 2'b11, d0: 8'h33, d1: 8'h44, exp_ready: 2'b01};
    tbl[4] = '{valid: 2'b10, d0: 8'hEE, d1: 8'h44, exp_ready: 2'b10};
    tbl[5] = '{valid: 2'b10, d0: 8'hEE, d1: 8'h55, exp_ready: 2'b10};
    tbl[6] = '{valid: 2'b01, d0: 8'h66, d1: 8'hEE, exp_ready: 2'b01};
    tbl[7] = '{valid: 2'b00, d0: 8'hEE, d1: 8'hEE, exp_ready: 2'b00};

    fork
      begin : watchdog
        #500us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
      begin : monitor
        int prev_cyc;
        bit have_prev;
        bit prev_more;
        have_prev = 1'b0;
        prev_more = 1'b0;
        prev_cyc  = 0;
        forever begin
          @(negedge clk);
          if (rst) begin
            have_prev = 1'b0;
          end else if (uart_wr_en) begin
            chk("pulse_pending", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              chk("wr_data_order", {24'd0, uart_wr_data}, {24'd0, exp_q.pop_front()});
            end
            if (have_prev && prev_more) begin
              chk("pulse_spacing", cyc - prev_cyc, FRAME_CLKS);
            end
            prev_cyc  = cyc;
            have_prev = 1'b1;
            prev_more = (exp_q.size() != 0);
            pulses++;
          end
        end
      end
    join_none

    // Reset state, with both requesters valid to show grants are held off.
    rst       = 1'b1;
    req_valid = 2'b11;
    req_data  = 16'h0000;
    repeat (2) @(posedge clk);
    at_sample();
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, uart_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, uart_wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    next_cyc();
    req_valid = 2'b00;
    rst       = 1'b0;
    next_cyc();

    // Fairness: both streaming, pointer starts at 0.
    ia = 0;
    ib = 0;
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      req_valid = {ib < 4, ia < 4};
      req_data  = {8'(8'hB0 + ib), 8'(8'hA0 + ia)};
      at_sample();
      er = (c % 2 == 0) ? 2'b01 : 2'b10;
      chk("fair_ready", {30'd0, req_ready}, {30'd0, er});
      if (er[0]) begin
        expect_byte(8'(8'hA0 + ia));
        ia++;
      end else begin
        expect_byte(8'(8'hB0 + ib));
        ib++;
      end
    end
    next_cyc();
    req_valid = 2'b00;
    wait_idle(300);

    // Single byte: 2-cycle latency, busy drops one cycle before the next slot.
    next_cyc();
    req_valid = 2'b01;
    req_data  = {8'h00, 8'h41};
    at_sample();
    chk("single_ready", {30'd0, req_ready}, 32'd1);
    expect_byte(8'h41);
    next_cyc();
    req_valid = 2'b00;
    at_sample();
    chk("single_wr_en_c1", {31'd0, uart_wr_en}, 32'd0);
    next_cyc();
    at_sample();
    chk("single_wr_en_c2", {31'd0, uart_wr_en}, 32'd1);
    chk("single_wr_data", {24'd0, uart_wr_data}, 32'h41);
    for (int c = 3; c <= 21; c++) begin
      next_cyc();
      at_sample();
      if (c == 20) chk("single_busy_hold", {31'd0, busy}, 32'd1);
      if (c == 21) chk("single_busy_fall", {31'd0, busy}, 32'd0);
    end

    // Arbitration vectors (pointer is 1 after the single-byte grant to req0).
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      req_valid = tbl[i].valid;
      req_data  = {tbl[i].d1, tbl[i].d0};
      at_sample();
      chk("tbl_ready", {30'd0, req_ready}, {30'd0, tbl[i].exp_ready});
      if (tbl[i].exp_ready[0]) expect_byte(tbl[i].d0);
      else if (tbl[i].exp_ready[1]) expect_byte(tbl[i].d1);
    end
    next_cyc();
    req_valid = 2'b00;
    wait_idle(200);

    // Full FIFO: accepts on cycles 0..8, then one slot per pop at 22, 42, 62.
    sent = 0;
    for (int c = 0; c < 200 && sent < 12; c++) begin
      next_cyc();
      req_valid = 2'b01;
      req_data  = {8'h00, 8'(8'hC0 + sent)};
      at_sample();
      er = (c <= 8 || c == 22 || c == 42 || c == 62) ? 2'b01 : 2'b00;
      chk("full_ready", {30'd0, req_ready}, {30'd0, er});
      if (c == 9)  chk("full_count_max", {28'd0, fifo_count}, 32'd8);
      if (c == 21) chk("full_count_pre_pop", {28'd0, fifo_count}, 32'd8);
      if (c == 22) chk("full_count_post_pop", {28'd0, fifo_count}, 32'd7);
      if (er[0]) begin
        expect_byte(8'(8'hC0 + sent));
        sent++;
      end
    end
    chk("full_all_sent", sent, 12);
    next_cyc();
    req_valid = 2'b00;
    wait_idle(400);

    // Push on the pop cycle with three bytes queued and FSM in IDLE.
    for (int c = 0; c <= 22; c++) begin
      next_cyc();
      req_valid = (c <= 3 || c == 21) ? 2'b01 : 2'b00;
      req_data  = {8'h00, (c == 21) ? 8'hD4 : 8'(8'hD0 + c)};
      at_sample();
      if (c <= 3 || c == 21) begin
        chk("pp_ready", {30'd0, req_ready}, 32'd1);
        expect_byte(req_data[7:0]);
      end
      if (c == 4)  chk("pp_count_c4", {28'd0, fifo_count}, 32'd3);
      if (c == 21) chk("pp_count_idle", {28'd0, fifo_count}, 32'd3);
      if (c == 22) begin
        chk("pp_count_after", {28'd0, fifo_count}, 32'd3);
        chk("pp_wr_en", {31'd0, uart_wr_en}, 32'd1);
      end
    end
    next_cyc();
    req_valid = 2'b00;
    wait_idle(200);

    // Asynchronous reset mid-WAIT with three bytes queued.
    for (int c = 0; c <= 10; c++) begin
      next_cyc();
      req_valid = (c <= 3) ? 2'b01 : 2'b00;
      req_data  = {8'h00, 8'(8'hE0 + c)};
      if (c <= 3) expect_byte(req_data[7:0]);
    end
    at_sample();
    chk("mid_count_before", {28'd0, fifo_count}, 32'd3);
    next_cyc();
    #2;
    req_valid = 2'b01;
    rst       = 1'b1;
    #1;
    chk("arst_ready", {30'd0, req_ready}, 32'd0);
    chk("arst_wr_en", {31'd0, uart_wr_en}, 32'd0);
    chk("arst_wr_data", {24'd0, uart_wr_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_count", {28'd0, fifo_count}, 32'd0);
    req_valid = 2'b00;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses_before = pulses;
    repeat (40) begin
      next_cyc();
      at_sample();
    end
    chk("post_rst_no_pulse", pulses - pulses_before, 0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // LF handling: expanded to CR,LF only with the CRLF build.
    for (int c = 0; c <= 42; c++) begin
      next_cyc();
      req_valid = (c <= 1) ? 2'b01 : 2'b00;
      req_data  = {8'h00, (c == 0) ? 8'h48 : 8'h0A};
      at_sample();
      if (c <= 1) begin
        chk("lf_ready", {30'd0, req_ready}, 32'd1);
        expect_byte(req_data[7:0]);
      end
      if (c == 2) begin
        chk("lf_wr_en_c2", {31'd0, uart_wr_en}, 32'd1);
        chk("lf_data_c2", {24'd0, uart_wr_data}, 32'h48);
      end
      if (c == 22) begin
        chk("lf_wr_en_c22", {31'd0, uart_wr_en}, 32'd1);
`ifdef UART_ARB_CRLF_EN
        chk("lf_data_c22", {24'd0, uart_wr_data}, 32'h0D);
`else
        chk("lf_data_c22", {24'd0, uart_wr_data}, 32'h0A);
`endif
      end
`ifdef UART_ARB_CRLF_EN
      if (c == 41) chk("lf_busy_pending", {31'd0, busy}, 32'd1);
      if (c == 42) begin
        chk("lf_wr_en_c42", {31'd0, uart_wr_en}, 32'd1);
        chk("lf_data_c42", {24'd0, uart_wr_data}, 32'h0A);
      end
`else
      if (c == 41) chk("lf_busy_done", {31'd0, busy}, 32'd0);
      if (c == 42) chk("lf_wr_en_c42", {31'd0, uart_wr_en}, 32'd0);
`endif
    end
    wait_idle(100);

    chk("queue_drained", exp_q.size(), 0);
`ifdef UART_ARB_CRLF_EN
    chk("pulse_total", pulses, 36);
`else
    chk("pulse_total", pulses, 35);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
